// File: rtl/bus_arbiter_if.sv
// Request/ack and register-bus signal bundle for bus_arbiter.
// master: arbiter view (drives bus + acks); slave: requesters + decode.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8
);
  logic [N_MASTERS-1:0]        m_req;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wr_data;
  logic [N_MASTERS-1:0]        m_ack;
  logic [DATA_W-1:0]           m_rd_data;
  logic [ADDR_W-1:0]           bus_addr;
  logic [DATA_W-1:0]           bus_wr_data;
  logic                        bus_we;
  logic                        bus_re;
  logic [DATA_W-1:0]           bus_rd_data;

  modport master (
    input  m_req, m_we, m_addr, m_wr_data,
    input  bus_rd_data,
    output m_ack, m_rd_data,
    output bus_addr, bus_wr_data, bus_we, bus_re
  );

  modport slave (
    output m_req, m_we, m_addr, m_wr_data,
    output bus_rd_data,
    input  m_ack, m_rd_data,
    input  bus_addr, bus_wr_data, bus_we, bus_re
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one register bus between N_MASTERS.
// Ports: clk, reset (sync, high), bif (bus_arbiter_if.master).
module bus_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  bus_arbiter_if.master   bif
);
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t               state;
  logic [IW-1:0]        last;
  logic [IW-1:0]        grant;
  logic [IW-1:0]        pick;
  logic                 any;
  logic                 l_we;
  logic [2:0]           cnt;
  logic [N_MASTERS-1:0] ack_r;
  logic [DATA_W-1:0]    rd_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [DATA_W-1:0]    wd_r;
  logic                 we_r;
  logic                 re_r;

  // Scan from last+1 with wrap so the previous winner goes to the back.
  always_comb begin
    int j;
    any  = 1'b0;
    pick = last;
    j    = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      j = (int'(last) + k) % N_MASTERS;
      if (!any && bif.m_req[j]) begin
        any  = 1'b1;
        pick = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last   <= IW'(N_MASTERS - 1);
      grant  <= '0;
      l_we   <= 1'b0;
      cnt    <= '0;
      ack_r  <= '0;
      rd_r   <= '0;
      addr_r <= '0;
      wd_r   <= '0;
      we_r   <= 1'b0;
      re_r   <= 1'b0;
    end else begin
      ack_r <= '0;
      we_r  <= 1'b0;
      re_r  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            grant  <= pick;
            last   <= pick;
            l_we   <= bif.m_we[pick];
            addr_r <= bif.m_addr[int'(pick)*ADDR_W +: ADDR_W];
            wd_r   <= bif.m_wr_data[int'(pick)*DATA_W +: DATA_W];
            // Strobe is registered here so it is high in the ISSUE cycle.
            we_r   <= bif.m_we[pick];
            re_r   <= !bif.m_we[pick];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (l_we) begin
            ack_r[grant] <= 1'b1;
            state        <= DONE;
          end else begin
            cnt   <= 3'(RD_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt <= 3'd1) begin
            rd_r         <= bif.bus_rd_data;
            ack_r[grant] <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bif.m_ack       = ack_r;
  assign bif.m_rd_data   = rd_r;
  assign bif.bus_addr    = addr_r;
  assign bif.bus_wr_data = wd_r;
  assign bif.bus_we      = we_r;
  assign bif.bus_re      = re_r;
endmodule
